// File: rtl/wptr_full_ctrl.sv
// Write-domain pointer/flag controller for the async FIFO: synchronises the read
// Gray pointer and keeps the binary/Gray write pointers, full, almost-full, level and overflow.
module wptr_full_ctrl #(
  parameter int ADDR_WIDTH  = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  winc,
  input  logic [ADDR_WIDTH:0]   rptr_gray,
  input  logic [ADDR_WIDTH:0]   af_thresh,
  input  logic                  ovf_clr,
  output logic                  wen,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [ADDR_WIDTH:0]   wptr_gray,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   wlevel,
  output logic                  overflow
);

  localparam int A = ADDR_WIDTH;

  logic [A:0] sync_q [SYNC_STAGES];
  logic [A:0] rq_gray;
  logic [A:0] rq_bin;
  logic [A:0] wbin_q, wbin_d;
  logic [A:0] wgray_q, wgray_d;
  logic [A:0] wlevel_q, wlevel_d;
  logic [A:0] full_cmp;
  logic       full_q, full_d;
  logic       af_q, af_d;
  logic       ovf_q, ovf_d;
  logic       wen_w;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= rptr_gray;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign rq_gray = sync_q[SYNC_STAGES-1];

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    rq_bin = '0;
    for (int i = 0; i <= A; i++) rq_bin[i] = ^(rq_gray >> i);
  end

  always_comb begin
    wen_w    = winc & ~full_q;
    wbin_d   = wbin_q + {{A{1'b0}}, wen_w};
    wgray_d  = wbin_d ^ (wbin_d >> 1);
    wlevel_d = wbin_d - rq_bin;
    // Write pointer one lap ahead of the read pointer: top two Gray bits inverted.
    full_cmp = {~rq_gray[A:A-1], rq_gray[A-2:0]};
    full_d   = (wgray_d == full_cmp);
    af_d     = (wlevel_d >= af_thresh);
    ovf_d    = (winc & full_q) | (ovf_q & ~ovf_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbin_q   <= '0;
      wgray_q  <= '0;
      wlevel_q <= '0;
      full_q   <= 1'b0;
      af_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wbin_q   <= wbin_d;
      wgray_q  <= wgray_d;
      wlevel_q <= wlevel_d;
      full_q   <= full_d;
      af_q     <= af_d;
      ovf_q    <= ovf_d;
    end
  end

  assign wen         = wen_w;
  assign waddr       = wbin_q[A-1:0];
  assign wptr_gray   = wgray_q;
  assign full        = full_q;
  assign almost_full = af_q;
  assign wlevel      = wlevel_q;
  assign overflow    = ovf_q;

endmodule

// File: doc/wptr_full_ctrl.md
Name: wptr_full_ctrl

Overview:
Write-domain pointer and flag controller for the parametrised async FIFO; successor to the basic write-pointer block. Synchronises the read-domain Gray pointer internally and maintains the binary and Gray write pointers. Produces full, programmable almost_full, fill level and a sticky overflow flag. Sits between the write client and the dual-port RAM write port, and drives the Gray pointer to the read-domain synchroniser.

Parameters:
ADDR_WIDTH, 6, RAM address bits; FIFO depth = 2**ADDR_WIDTH; legal range >= 2
SYNC_STAGES, 2, flop stages in the internal rptr synchroniser; legal range >= 2

Ports:
clk  in  1  write-domain clock
rst_n  in  1  asynchronous active-low reset
winc  in  1  write request from client
rptr_gray  in  ADDR_WIDTH+1  read pointer, Gray-coded, from the read clock domain (asynchronous)
af_thresh  in  ADDR_WIDTH+1  almost-full threshold in entries; quasi-static
ovf_clr  in  1  clears sticky overflow
wen  out  1  RAM write enable = winc & ~full (combinational)
waddr  out  ADDR_WIDTH  RAM write address = registered binary pointer LSBs
wptr_gray  out  ADDR_WIDTH+1  registered Gray write pointer, to read domain
full  out  1  FIFO full (registered)
almost_full  out  1  wlevel >= af_thresh (registered)
wlevel  out  ADDR_WIDTH+1  write-side fill level, 0..DEPTH (registered)
overflow  out  1  sticky: write attempted while full

Behaviour:
- Reset (async assert, sync release): all flops, including every synchroniser stage, go to 0. Outputs: waddr=0, wptr_gray=0, full=0, almost_full=0, wlevel=0, overflow=0. wen follows winc (full=0).
- Reset asserted mid-operation: immediate clear as above. No pending write survives the reset.
- Synchroniser: rptr_gray passes through SYNC_STAGES flops -> rq_gray. rq_bin = Gray-to-binary(rq_gray), combinational XOR-prefix.
- Pointer update each clk: wbin_next = wbin + (winc & ~full), width ADDR_WIDTH+1, wraps modulo 2**(ADDR_WIDTH+1). wgray_next = wbin_next ^ (wbin_next >> 1). wbin <= wbin_next; wptr_gray <= wgray_next. Only one Gray bit changes per cycle.
- waddr = wbin[ADDR_WIDTH-1:0]. It is the binary address, not Gray.
- full <= (wgray_next == {~rq_gray[A:A-1], rq_gray[A-2:0]}), where A=ADDR_WIDTH. full asserts on the clock edge that accepts the DEPTH-th outstanding write.
- wlevel <= wbin_next - rq_bin (modulo 2**(A+1)).
- almost_full <= (wbin_next - rq_bin) >= af_thresh. With af_thresh=0, almost_full is 1 from the first clk after reset. With af_thresh > DEPTH, almost_full never asserts.
- Write while full: pointers hold, wen=0, no RAM write. overflow <= 1 on the same edge.
- overflow is sticky until ovf_clr. If ovf_clr and a new overflow event occur in the same cycle, set wins (overflow stays 1).
- Pessimism: a read is seen SYNC_STAGES+1 clk edges after rptr_gray changes. full and almost_full may stay asserted conservatively until then. Never optimistic.
- Simultaneous winc and an rptr change: both are applied in the same wlevel computation. No false full.
- Wrap-around: after 2**(A+1) writes, wbin returns to 0. The MSB/second-MSB inversion in the full compare handles the wrap. Gray sequence continuity is required.

Test Plan:
(All with ADDR_WIDTH=4, DEPTH=16, SYNC_STAGES=2.)
1. Reset: drive rst_n=0 with winc=1 -> all registered outputs 0 during reset. After release, first accepted write gives waddr=1, wptr_gray=5'b00001, wlevel=1.
2. Fill: rptr_gray held 0, winc=1 for 16 cycles -> waddr steps 0..15, wptr_gray follows 00000,00001,00011,00010,... full=1 on the edge accepting write 16, wlevel=16, wptr_gray=5'b11000.
3. Overflow: continue winc=1 while full -> wen=0, wptr_gray stays 11000, overflow=1. Pulse ovf_clr with winc=0 -> overflow=0. Pulse ovf_clr with winc=1 while full -> overflow stays 1.
4. Drain visibility: from full, set rptr_gray=gray(4)=5'b00110 -> full=0 and wlevel=12 exactly 3 clk edges later (SYNC_STAGES+1), not earlier.
5. Almost-full: af_thresh=12, empty FIFO, write 12 entries -> almost_full=1 on the edge where wlevel becomes 12, and 0 at wlevel=11. Set af_thresh=17 -> almost_full stays 0 even when full.
6. Wrap: 40 writes with rptr_gray tracking writes at lag 3 -> wbin wraps 31->0 (wptr_gray 10000->00000). full never asserts, wlevel stays 3, waddr wraps 15->0.
